// File: rtl/ysyx_23060077_ifu_pkg.sv
// ysyx_23060077_ifu_pkg: shared constants for the fetch unit.
// Provides the opcode encodings used by pre-decode, the NOP used to replace
// faulting fetches, the reset PC and the core data-path widths.
package ysyx_23060077_ifu_pkg;
   localparam int          YSYX_23060077_INST_WIDTH = 32;
   localparam int          YSYX_23060077_DATA_WIDTH = 32;
   localparam logic [31:0] YSYX_23060077_RESET_PC   = 32'h3000_0000;
   localparam logic [31:0] YSYX_23060077_INST_NOP   = 32'h0000_0013;
   localparam logic [6:0]  YSYX_23060077_OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  YSYX_23060077_OPC_JALR   = 7'b1100111;
   localparam logic [6:0]  YSYX_23060077_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  YSYX_23060077_OPC_SYS    = 7'b1110011;
endpackage

// File: rtl/ysyx_23060077_ifu_predecode.sv
// ysyx_23060077_ifu_predecode: combinational opcode classifier.
// Ports: opcode (inst[6:0]) in; jal, jalr, branch, sys flags out.
module ysyx_23060077_ifu_predecode
   import ysyx_23060077_ifu_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       jal,
   output logic       jalr,
   output logic       branch,
   output logic       sys
);
   assign jal    = opcode == YSYX_23060077_OPC_JAL;
   assign jalr   = opcode == YSYX_23060077_OPC_JALR;
   assign branch = opcode == YSYX_23060077_OPC_BRANCH;
   assign sys    = opcode == YSYX_23060077_OPC_SYS;
endmodule

// File: rtl/ysyx_23060077_ifu.sv
// ysyx_23060077_ifu: instruction fetch unit, producer side of the decode interface.
// Ports: clock/reset; AR channel (ifu_arvalid/arready/araddr); R channel
// (ifu_rvalid/rready/rdata/rresp); redirect_valid/redirect_pc from execute;
// inst_valid/inst_ready/inst/inst_pc to decode with idu_* pre-decode flags
// and fetch_fault for responses with a nonzero rresp.
module ysyx_23060077_ifu
   import ysyx_23060077_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = YSYX_23060077_RESET_PC,
   parameter int          ADDR_WIDTH = 32,
   parameter int          INST_WIDTH = YSYX_23060077_INST_WIDTH
)(
   input  logic                  clock,
   input  logic                  reset,
   output logic                  ifu_arvalid,
   input  logic                  ifu_arready,
   output logic [ADDR_WIDTH-1:0] ifu_araddr,
   input  logic                  ifu_rvalid,
   output logic                  ifu_rready,
   input  logic [INST_WIDTH-1:0] ifu_rdata,
   input  logic [1:0]            ifu_rresp,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [INST_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic                  idu_jal,
   output logic                  idu_jalr,
   output logic                  idu_branch,
   output logic                  idu_sys,
   output logic                  fetch_fault
);
   typedef enum logic [1:0] {IDLE, AR, R, OUT} state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n, araddr_n;
   logic                  kill, kill_n, cap;
   logic                  pd_jal, pd_jalr, pd_branch, pd_sys;
   logic                  fault;

   ysyx_23060077_ifu_predecode u_pd (
      .opcode (ifu_rdata[6:0]),
      .jal    (pd_jal),
      .jalr   (pd_jalr),
      .branch (pd_branch),
      .sys    (pd_sys)
   );

   assign ifu_arvalid = state == AR;
   assign ifu_rready  = state == R;
   assign inst_valid  = state == OUT;
   assign fault       = |ifu_rresp;

   // A redirect while a beat is in flight only retargets pc and sets kill;
   // the returning beat is then swallowed and the fetch restarts from pc.
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      araddr_n = ifu_araddr;
      kill_n   = kill;
      cap      = 1'b0;
      case (state)
         IDLE: begin
            state_n  = AR;
            pc_n     = redirect_valid ? redirect_pc : pc;
            araddr_n = pc_n;
         end
         AR: begin
            state_n = ifu_arready ? R : AR;
            if (redirect_valid) begin
               pc_n   = redirect_pc;
               kill_n = 1'b1;
            end
         end
         R: begin
            if (ifu_rvalid && (redirect_valid || kill)) begin
               state_n  = AR;
               kill_n   = 1'b0;
               pc_n     = redirect_valid ? redirect_pc : pc;
               araddr_n = pc_n;
            end else if (ifu_rvalid) begin
               state_n = OUT;
               cap     = 1'b1;
            end else if (redirect_valid) begin
               pc_n   = redirect_pc;
               kill_n = 1'b1;
            end
         end
         default: begin
            // Redirect wins over a same-cycle handshake.
            if (redirect_valid || inst_ready) begin
               state_n  = AR;
               pc_n     = redirect_valid ? redirect_pc : pc + ADDR_WIDTH'(4);
               araddr_n = pc_n;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= ADDR_WIDTH'(RESET_PC);
         ifu_araddr  <= '0;
         kill        <= 1'b0;
         inst        <= '0;
         inst_pc     <= '0;
         idu_jal     <= 1'b0;
         idu_jalr    <= 1'b0;
         idu_branch  <= 1'b0;
         idu_sys     <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         ifu_araddr <= araddr_n;
         kill       <= kill_n;
         if (cap) begin
            inst        <= fault ? INST_WIDTH'(YSYX_23060077_INST_NOP) : ifu_rdata;
            inst_pc     <= ifu_araddr;
            idu_jal     <= pd_jal & ~fault;
            idu_jalr    <= pd_jalr & ~fault;
            idu_branch  <= pd_branch & ~fault;
            idu_sys     <= pd_sys & ~fault;
            fetch_fault <= fault;
         end
      end
   end
endmodule
